// File: rtl/carry_tree_seq_ctrl_if.sv
// carry_tree_seq_ctrl_if
//   Groups the operand and result handshakes of carry_tree_seq_ctrl.
//   master : requester/consumer side (drives operands and out_ready)
//   slave  : controller side (drives ready/valid, result and status)
// Signals
//   in_valid/in_ready   operand handshake; a, b, cin sampled on it
//   out_valid/out_ready result handshake; sum, cout, mismatch held during it
//   busy                controller is in RUN or DONE
interface carry_tree_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             mismatch;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, mismatch, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, mismatch, busy
  );
endinterface

// File: rtl/carry_tree_seq_ctrl.sv
// carry_tree / carry_tree_seq_ctrl
//   carry_tree: combinational 4-bit adder slice computing the sum with three
//   parallel-prefix carry networks (Kogge-Stone, Brent-Kung, Sklansky).
//     a_i, b_i, cin_i      slice operands and carry-in
//     ksa_o, bka_o, ska_o  {cout, sum[3:0]} from each network
//   carry_tree_seq_ctrl: performs a WIDTH-bit add one nibble per clock,
//   LS nibble first, through a single shared carry_tree, rippling the carry
//   in a register. Returns the Kogge-Stone result and flags any slice where
//   the other two networks disagree with it.
//     clk       rising-edge clock
//     rst       asynchronous active-high reset
//     ctrl_if   operand/result handshake bundle (slave modport)
//   WIDTH must be a multiple of 4 and at least 4.

module carry_tree (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [4:0] ksa_o,
  output logic [4:0] bka_o,
  output logic [4:0] ska_o
);
  // Prefix operator on {generate, propagate}; hi spans the more significant bits.
  function automatic logic [1:0] gp_dot(input logic [1:0] hi, input logic [1:0] lo);
    return {hi[1] | (hi[0] & lo[1]), hi[0] & lo[0]};
  endfunction

  // Builds {cout, sum} from bit propagates and carries c4..c1 plus carry-in c0.
  function automatic logic [4:0] pack_sum(input logic [3:0] p, input logic [3:0] c_hi,
                                          input logic c0);
    return {c_hi[3], p ^ {c_hi[2:0], c0}};
  endfunction

  logic [3:0] p_s;
  logic [1:0] gp_s  [4];
  logic [1:0] ks1_s [4];
  logic [1:0] ks2_s [4];
  logic [1:0] bk01_s, bk23_s, bk02_s, bk03_s;
  logic [1:0] sk01_s, sk23_s, sk02_s, sk03_s;

  // Three prefix networks over the same bit-level generate/propagate pairs.
  always_comb begin
    p_s = a_i ^ b_i;
    // Carry-in is folded into bit 0 so every prefix node directly yields a carry.
    gp_s[0] = gp_dot({a_i[0] & b_i[0], p_s[0]}, {cin_i, 1'b0});
    for (int i = 1; i < 4; i++) begin
      gp_s[i] = {a_i[i] & b_i[i], p_s[i]};
    end

    // Kogge-Stone: spans 1 then 2, every bit combined at every level.
    ks1_s[0] = gp_s[0];
    for (int i = 1; i < 4; i++) begin
      ks1_s[i] = gp_dot(gp_s[i], gp_s[i-1]);
    end
    ks2_s[0] = ks1_s[0];
    ks2_s[1] = ks1_s[1];
    for (int i = 2; i < 4; i++) begin
      ks2_s[i] = gp_dot(ks1_s[i], ks1_s[i-2]);
    end
    ksa_o = pack_sum(p_s, {ks2_s[3][1], ks2_s[2][1], ks2_s[1][1], ks2_s[0][1]}, cin_i);

    // Brent-Kung: pairwise up-sweep, then down-sweep fills bit 2.
    bk01_s = gp_dot(gp_s[1], gp_s[0]);
    bk23_s = gp_dot(gp_s[3], gp_s[2]);
    bk03_s = gp_dot(bk23_s, bk01_s);
    bk02_s = gp_dot(gp_s[2], bk01_s);
    bka_o  = pack_sum(p_s, {bk03_s[1], bk02_s[1], bk01_s[1], gp_s[0][1]}, cin_i);

    // Sklansky: lower-half prefix fans out to both upper-half bits.
    sk01_s = gp_dot(gp_s[1], gp_s[0]);
    sk23_s = gp_dot(gp_s[3], gp_s[2]);
    sk02_s = gp_dot(gp_s[2], sk01_s);
    sk03_s = gp_dot(sk23_s, sk01_s);
    ska_o  = pack_sum(p_s, {sk03_s[1], sk02_s[1], sk01_s[1], gp_s[0][1]}, cin_i);
  end
endmodule

module carry_tree_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input logic              clk,
  input logic              rst,
  carry_tree_seq_ctrl_if.slave ctrl_if
);
  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             mismatch_q, mismatch_d;

  logic [3:0] a_slice_s;
  logic [3:0] b_slice_s;
  logic [4:0] ksa_s, bka_s, ska_s;

  assign a_slice_s = a_q[{k_q, 2'b00} +: 4];
  assign b_slice_s = b_q[{k_q, 2'b00} +: 4];

  carry_tree u_slice (
    .a_i   (a_slice_s),
    .b_i   (b_slice_s),
    .cin_i (carry_q),
    .ksa_o (ksa_s),
    .bka_o (bka_s),
    .ska_o (ska_s)
  );

  // State, slice index, operand and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      a_q        <= a_d;
      b_q        <= b_d;
      carry_q    <= carry_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      mismatch_q <= mismatch_d;
    end
  end

  // Next-state and datapath updates for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    mismatch_d = mismatch_q;

    case (state_q)
      IDLE: begin
        if (ctrl_if.in_valid) begin
          a_d        = ctrl_if.a;
          b_d        = ctrl_if.b;
          carry_d    = ctrl_if.cin;
          k_d        = '0;
          sum_d      = '0;
          cout_d     = 1'b0;
          mismatch_d = 1'b0;
          state_d    = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        sum_d[{k_q, 2'b00} +: 4] = ksa_s[3:0];
        carry_d                  = ksa_s[4];
        // Sticky across the transaction's slices; cleared only on accept.
        if ((bka_s != ksa_s) || (ska_s != ksa_s)) begin
          mismatch_d = 1'b1;
        end else begin
          mismatch_d = mismatch_q;
        end
        if (k_q == K_LAST) begin
          cout_d  = ksa_s[4];
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d     = k_q + KW'(1);
          state_d = RUN;
        end
      end

      DONE: begin
        if (ctrl_if.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake/status flags decode from the registered state only.
  assign ctrl_if.in_ready  = (state_q == IDLE);
  assign ctrl_if.out_valid = (state_q == DONE);
  assign ctrl_if.busy      = (state_q == RUN) || (state_q == DONE);
  assign ctrl_if.sum       = sum_q;
  assign ctrl_if.cout      = cout_q;
  assign ctrl_if.mismatch  = mismatch_q;
endmodule

// File: tb/tb_carry_tree_seq_ctrl.sv
// Directed and randomised checks of carry_tree_seq_ctrl at WIDTH=16 and 32.
module tb_carry_tree_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  carry_tree_seq_ctrl_if #(.WIDTH(16)) if16 ();
  carry_tree_seq_ctrl_if #(.WIDTH(32)) if32 ();

  carry_tree_seq_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .ctrl_if(if16));
  carry_tree_seq_ctrl #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .ctrl_if(if32));

  task automatic test_reset();
    rst = 1'b1;
    if16.in_valid = 1'b0; if16.a = 16'h0; if16.b = 16'h0; if16.cin = 1'b0; if16.out_ready = 1'b0;
    if32.in_valid = 1'b0; if32.a = 32'h0; if32.b = 32'h0; if32.cin = 1'b0; if32.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (if16.in_ready !== 1'b1 || if16.out_valid !== 1'b0 || if16.busy !== 1'b0 ||
        if16.sum !== 16'h0 || if16.cout !== 1'b0 || if16.mismatch !== 1'b0) begin
      errors++;
      $display("FAIL reset16: got rdy=%b ov=%b busy=%b sum=%h cout=%b mm=%b, want 1 0 0 0000 0 0",
               if16.in_ready, if16.out_valid, if16.busy, if16.sum, if16.cout, if16.mismatch);
    end
    checks++;
    if (if32.in_ready !== 1'b1 || if32.out_valid !== 1'b0 || if32.busy !== 1'b0 ||
        if32.sum !== 32'h0 || if32.cout !== 1'b0 || if32.mismatch !== 1'b0) begin
      errors++;
      $display("FAIL reset32: got rdy=%b ov=%b busy=%b sum=%h cout=%b mm=%b, want 1 0 0 0 0 0",
               if32.in_ready, if32.out_valid, if32.busy, if32.sum, if32.cout, if32.mismatch);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (if16.in_ready !== 1'b1 || if16.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got rdy=%b busy=%b, want 1 0", if16.in_ready, if16.busy);
    end
  endtask

  task automatic test_latency();
    int cyc;
    if16.a = 16'hFFFF; if16.b = 16'h0001; if16.cin = 1'b0; if16.in_valid = 1'b1;
    checks++;
    if (if16.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL latency_ready: got in_ready=%b, want 1", if16.in_ready);
    end
    @(negedge clk);
    if16.in_valid = 1'b0;
    cyc = 1;
    while (if16.out_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != 5) begin
      errors++;
      $display("FAIL latency_cycles: got %0d, want 5", cyc);
    end
    checks++;
    if ({if16.cout, if16.sum} !== 17'h10000 || if16.mismatch !== 1'b0) begin
      errors++;
      $display("FAIL latency_result: got cout=%b sum=%h mm=%b, want 1 0000 0",
               if16.cout, if16.sum, if16.mismatch);
    end
    checks++;
    if (if16.busy !== 1'b1 || if16.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL done_flags: got busy=%b rdy=%b, want 1 0", if16.busy, if16.in_ready);
    end
    if16.out_ready = 1'b1;
    @(negedge clk);
    if16.out_ready = 1'b0;
    checks++;
    if (if16.in_ready !== 1'b1 || if16.out_valid !== 1'b0 || if16.busy !== 1'b0) begin
      errors++;
      $display("FAIL release_idle: got rdy=%b ov=%b busy=%b, want 1 0 0",
               if16.in_ready, if16.out_valid, if16.busy);
    end
  endtask

  task automatic test_back_to_back();
    int          nrise;
    int          rise_cyc [2];
    logic [16:0] res [2];
    logic        prev;
    nrise = 0; rise_cyc[0] = 0; rise_cyc[1] = 0; res[0] = 17'h0; res[1] = 17'h0; prev = 1'b0;
    if16.a = 16'h1234; if16.b = 16'h4321; if16.cin = 1'b1; if16.in_valid = 1'b1;
    if16.out_ready = 1'b1;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        if16.a = 16'h8000; if16.b = 16'h8000; if16.cin = 1'b0;
      end
      if (cyc == 7) if16.in_valid = 1'b0;
      if (if16.out_valid === 1'b1 && !prev && nrise < 2) begin
        rise_cyc[nrise] = cyc;
        res[nrise]      = {if16.cout, if16.sum};
        nrise++;
      end
      prev = if16.out_valid;
    end
    if16.out_ready = 1'b0;
    checks++;
    if (nrise != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d results, want 2", nrise);
    end
    checks++;
    if (rise_cyc[0] != 5) begin
      errors++;
      $display("FAIL b2b_first_latency: got %0d, want 5", rise_cyc[0]);
    end
    checks++;
    if (rise_cyc[1] != 11) begin
      errors++;
      $display("FAIL b2b_interval: got second at %0d, want 11", rise_cyc[1]);
    end
    checks++;
    if (res[0] !== 17'h05556) begin
      errors++;
      $display("FAIL b2b_res0: got %h, want 05556", res[0]);
    end
    checks++;
    if (res[1] !== 17'h10000) begin
      errors++;
      $display("FAIL b2b_res1: got %h, want 10000", res[1]);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    if16.a = 16'h0F0F; if16.b = 16'h00F1; if16.cin = 1'b0; if16.in_valid = 1'b1;
    @(negedge clk);
    if16.in_valid = 1'b0;
    cyc = 1;
    while (if16.out_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (if16.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_timeout: got out_valid=%b, want 1", if16.out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (if16.out_valid !== 1'b1 || if16.sum !== 16'h1000 || if16.cout !== 1'b0 ||
          if16.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got ov=%b sum=%h cout=%b rdy=%b, want 1 1000 0 0",
                 i, if16.out_valid, if16.sum, if16.cout, if16.in_ready);
      end
      if (i < 4) @(negedge clk);
    end
    if16.out_ready = 1'b1;
    @(negedge clk);
    if16.out_ready = 1'b0;
    checks++;
    if (if16.in_ready !== 1'b1 || if16.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got rdy=%b ov=%b, want 1 0", if16.in_ready, if16.out_valid);
    end
  endtask

  task automatic test_ignored_inputs();
    int cyc;
    if16.a = 16'h00FF; if16.b = 16'h0101; if16.cin = 1'b0; if16.in_valid = 1'b1;
    @(negedge clk);
    if16.in_valid  = 1'b0;
    if16.out_ready = 1'b1;
    @(negedge clk);
    if16.out_ready = 1'b0;
    if16.a = 16'hFFFF; if16.b = 16'hFFFF; if16.cin = 1'b1; if16.in_valid = 1'b1;
    cyc = 2;
    while (if16.out_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (if16.out_valid !== 1'b1 || if16.sum !== 16'h0200 || if16.cout !== 1'b0 ||
          if16.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL ignore_hold%0d: got ov=%b sum=%h cout=%b rdy=%b, want 1 0200 0 0",
                 i, if16.out_valid, if16.sum, if16.cout, if16.in_ready);
      end
      @(negedge clk);
    end
    if16.in_valid  = 1'b0;
    if16.out_ready = 1'b1;
    @(negedge clk);
    if16.out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (if16.in_ready !== 1'b1 || if16.busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_no_accept: got rdy=%b busy=%b, want 1 0", if16.in_ready, if16.busy);
    end
  endtask

  task automatic test_async_reset();
    int   cyc;
    logic phantom;
    if16.a = 16'hAAAA; if16.b = 16'h5555; if16.cin = 1'b0; if16.in_valid = 1'b1;
    @(negedge clk);
    if16.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (if16.in_ready !== 1'b1 || if16.out_valid !== 1'b0 || if16.busy !== 1'b0 ||
        if16.sum !== 16'h0 || if16.cout !== 1'b0 || if16.mismatch !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got rdy=%b ov=%b busy=%b sum=%h cout=%b mm=%b, want 1 0 0 0000 0 0",
               if16.in_ready, if16.out_valid, if16.busy, if16.sum, if16.cout, if16.mismatch);
    end
    @(negedge clk);
    rst = 1'b0;
    phantom = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (if16.out_valid !== 1'b0 || if16.busy !== 1'b0) phantom = 1'b1;
    end
    checks++;
    if (phantom !== 1'b0) begin
      errors++;
      $display("FAIL async_phantom: got activity=%b, want 0", phantom);
    end
    if16.a = 16'h0000; if16.b = 16'h0000; if16.cin = 1'b1; if16.in_valid = 1'b1;
    @(negedge clk);
    if16.in_valid = 1'b0;
    cyc = 1;
    while (if16.out_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (if16.out_valid !== 1'b1 || {if16.cout, if16.sum} !== 17'h00001) begin
      errors++;
      $display("FAIL post_reset_op: got ov=%b cout=%b sum=%h, want 1 0 0001",
               if16.out_valid, if16.cout, if16.sum);
    end
    if16.out_ready = 1'b1;
    @(negedge clk);
    if16.out_ready = 1'b0;
  endtask

  task automatic test_random16(input int n);
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] exp;
    int          stall, cyc;
    for (int v = 0; v < n; v++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rc  = 1'($urandom_range(0, 1));
      exp = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
      stall = $urandom_range(0, 2);
      repeat (stall) @(negedge clk);
      if16.a = ra; if16.b = rb; if16.cin = rc; if16.in_valid = 1'b1;
      @(negedge clk);
      if16.in_valid = 1'b0;
      cyc = 0;
      while (if16.out_valid !== 1'b1 && cyc < 40) begin
        if16.out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        cyc++;
      end
      if16.out_ready = 1'b0;
      stall = $urandom_range(0, 3);
      repeat (stall) @(negedge clk);
      checks++;
      if (if16.out_valid !== 1'b1 || {if16.cout, if16.sum} !== exp || if16.mismatch !== 1'b0) begin
        errors++;
        $display("FAIL rand16 #%0d a=%h b=%h cin=%b: got ov=%b res=%h mm=%b, want 1 %h 0",
                 v, ra, rb, rc, if16.out_valid, {if16.cout, if16.sum}, if16.mismatch, exp);
      end
      if16.out_ready = 1'b1;
      @(negedge clk);
      if16.out_ready = 1'b0;
    end
  endtask

  task automatic test_random32(input int n);
    logic [31:0] ra, rb;
    logic        rc;
    logic [32:0] exp;
    int          stall, cyc;
    for (int v = 0; v < n; v++) begin
      ra  = $urandom;
      rb  = $urandom;
      rc  = 1'($urandom_range(0, 1));
      exp = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
      stall = $urandom_range(0, 2);
      repeat (stall) @(negedge clk);
      if32.a = ra; if32.b = rb; if32.cin = rc; if32.in_valid = 1'b1;
      @(negedge clk);
      if32.in_valid = 1'b0;
      cyc = 0;
      while (if32.out_valid !== 1'b1 && cyc < 40) begin
        if32.out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        cyc++;
      end
      if32.out_ready = 1'b0;
      stall = $urandom_range(0, 3);
      repeat (stall) @(negedge clk);
      checks++;
      if (if32.out_valid !== 1'b1 || {if32.cout, if32.sum} !== exp || if32.mismatch !== 1'b0) begin
        errors++;
        $display("FAIL rand32 #%0d a=%h b=%h cin=%b: got ov=%b res=%h mm=%b, want 1 %h 0",
                 v, ra, rb, rc, if32.out_valid, {if32.cout, if32.sum}, if32.mismatch, exp);
      end
      if32.out_ready = 1'b1;
      @(negedge clk);
      if32.out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_backpressure();
    test_ignored_inputs();
    test_async_reset();
    test_random16(500);
    test_random32(500);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/carry_tree_seq_ctrl.md
# carry_tree_seq_ctrl

Sequencing controller that performs WIDTH-bit additions by driving one shared 4-bit `CarryTree` slice (Kogge-Stone, Brent-Kung and Sklansky results) for one nibble per clock, least-significant nibble first, rippling the carry between cycles. It accepts operands over a valid/ready handshake and returns the Kogge-Stone sum and carry-out over a second handshake. It also cross-checks the three prefix architectures on every slice and flags any disagreement. It sits between a requester and the adder datapath as its only sequencer.

## Interface
- `WIDTH`, default 16. Operand width; must be a multiple of 4 and at least 4. N = WIDTH/4 slice cycles.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  requester presents `a`, `b`, `cin`.
- `in_ready`  out  1  controller can accept; high only in IDLE.
- `a`, `b`  in  WIDTH  operands; sampled on input handshake.
- `cin`  in  1  carry-in; sampled on input handshake.
- `out_valid`  out  1  result available; high only in DONE.
- `out_ready`  in  1  consumer accepts result.
- `sum`  out  WIDTH  registered result, `a+b+cin` mod 2^WIDTH.
- `cout`  out  1  registered carry-out of the MSB slice.
- `mismatch`  out  1  sticky per transaction: BKA or SKA sum/cout differed from KSA on some slice.
- `busy`  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`: latch `a`, `b`, set carry register to `cin`, set slice index k=0, clear `sum`, `cout` and `mismatch`, then go to RUN.
- RUN, slice k: the slice is fed `a_reg[4k+3:4k]`, `b_reg[4k+3:4k]` and the carry register. At the clock edge, write the KSA sum to `sum[4k+3:4k]` and the KSA cout to the carry register. If BKA or SKA sum/cout differs from KSA, set `mismatch`. If k = N-1, write `cout` and go to DONE; otherwise k <= k+1.
- DONE: `out_valid`=1, and `sum`, `cout`, `mismatch` are held stable. On `out_ready`, go to IDLE.
- Ignored inputs: `in_valid` in RUN and DONE (no queuing), and `out_ready` outside DONE.
- Width rule: internal add is 5 bits per slice (4 sum + carry). The full result is exactly the (WIDTH+1)-bit `a+b+cin`.
- Reset (any state, any time): go to IDLE, k=0, carry register=0. Outputs: `sum`=0, `cout`=0, `mismatch`=0, `out_valid`=0, `busy`=0, `in_ready`=1. An in-flight transaction is discarded and no `out_valid` is produced for it.

## Timing
- Input accepted at edge t. RUN occupies cycles t+1..t+N. DONE is entered at edge t+N, and `out_valid` is high from cycle t+N+1.
- Latency is N+1 cycles from input handshake to `out_valid` (5 for WIDTH=16).
- On an output handshake at edge u, the FSM is in IDLE from cycle u+1 with `in_ready`=1.
- Minimum initiation interval is N+2 cycles.
- `in_ready`, `out_valid` and `busy` decode from the registered state only; no combinational path runs from `in_valid` or `out_ready` to any output.
- `out_valid`, once high, stays high with stable data until `out_ready` is sampled high.
- All slice arithmetic completes within one clock. The `CarryTree` slice is purely combinational.

## Test plan
- WIDTH=16, `a`=0xFFFF, `b`=0x0001, `cin`=0 -> `sum`=0x0000, `cout`=1, `mismatch`=0, `out_valid` rises exactly 5 cycles after accept.
- `a`=0x1234, `b`=0x4321, `cin`=1 -> `sum`=0x5556, `cout`=0. Then `a`=0x8000, `b`=0x8000, `cin`=0 -> `sum`=0x0000, `cout`=1, back to back with `out_ready` tied high, giving 6-cycle initiation.
- Backpressure: result `a`=0x0F0F, `b`=0x00F1, `cin`=0 (`sum`=0x1000) with `out_ready` low for 4 cycles -> `out_valid` stays 1, `sum`=0x1000 stable, `in_ready` stays 0. Release -> IDLE next cycle.
- `in_valid` pulsed with other operands during RUN and DONE -> not accepted, and the current result is unaffected.
- Assert `rst` asynchronously mid-RUN (k=2) -> all outputs at reset values immediately, no `out_valid` for the aborted op, and the next op `a`=0x0000, `b`=0x0000, `cin`=1 returns `sum`=0x0001.
- 1000 random vectors (WIDTH=16 and WIDTH=32) with random handshake stalls -> `{cout,sum}` equals `a+b+cin` for every vector, and `mismatch` stays 0.
